// File: rtl/instr_fetch_stage_if.sv
// instr_fetch_stage_if: instruction memory read bus between the fetch stage (master) and memory (slave).
interface instr_fetch_stage_if #(parameter int AW = 32, parameter int IW = 16);
   logic          rd;
   logic [AW-1:0] addr;
   logic [IW-1:0] rdata;
   logic          ack;
   modport master (output rd, addr, input rdata, ack);
   modport slave (input rd, addr, output rdata, ack);
endinterface

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: fetches 1- or 2-halfword instructions at the PC into IF/ID, drives PC advance.
module instr_fetch_stage #(
   parameter int AW       = 32,
   parameter int IW       = 16,
   parameter int LONG_BIT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [AW-1:0]       pc_i,
   output logic [AW-1:0]       next_pc_o,
   output logic                pc_enable_o,
   input  logic                flush_i,
   input  logic                stall_i,
   instr_fetch_stage_if.master imem,
   output logic                ifid_valid_o,
   output logic [31:0]         ifid_instr_o,
   output logic [AW-1:0]       ifid_pc_o,
   output logic [AW-1:0]       ifid_next_pc_o
);
   typedef enum logic [2:0] {ISSUE, REQ1, REQ2, PEND, DRAIN} state_t;
   state_t        state_q;
   logic [AW-1:0] addr_q, imem_addr_q, ifid_pc_q, ifid_npc_q;
   logic [IW-1:0] word1_q;
   logic [31:0]   pend_instr_q, ifid_instr_q, instr_d;
   logic [1:0]    len_q, len_d;
   logic          rd_q, valid_q, is_long, done, write;

   assign is_long = imem.rdata[LONG_BIT];
   assign done    = imem.ack && (state_q == REQ2 || (state_q == REQ1 && !is_long));
   assign len_d   = state_q == REQ1 ? (is_long ? 2'd2 : 2'd1) : state_q == REQ2 ? 2'd2 : len_q;
   assign instr_d = state_q == REQ1 ? {imem.rdata, 16'h0000} :
                    state_q == REQ2 ? {word1_q, imem.rdata} : pend_instr_q;
   // A completed (or parked) instruction moves into IF/ID only if decode can take it.
   assign write          = !flush_i && (done || state_q == PEND) && (!valid_q || !stall_i);
   assign pc_enable_o    = write || flush_i;
   assign next_pc_o      = addr_q + AW'(len_d);
   assign imem.rd        = rd_q;
   assign imem.addr      = imem_addr_q;
   assign ifid_valid_o   = valid_q;
   assign ifid_instr_o   = ifid_instr_q;
   assign ifid_pc_o      = ifid_pc_q;
   assign ifid_next_pc_o = ifid_npc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ISSUE;
         addr_q       <= '0;
         imem_addr_q  <= '0;
         word1_q      <= '0;
         pend_instr_q <= '0;
         len_q        <= 2'd1;
         rd_q         <= 1'b0;
         valid_q      <= 1'b0;
         ifid_instr_q <= '0;
         ifid_pc_q    <= '0;
         ifid_npc_q   <= '0;
      end else begin
         if (write) begin
            valid_q      <= 1'b1;
            ifid_instr_q <= instr_d;
            ifid_pc_q    <= addr_q;
            ifid_npc_q   <= next_pc_o;
         end else if (flush_i || !stall_i) begin
            valid_q <= 1'b0;
         end
         case (state_q)
            ISSUE: begin
               addr_q <= pc_i;
               if (!flush_i) begin
                  state_q     <= REQ1;
                  rd_q        <= 1'b1;
                  imem_addr_q <= pc_i;
               end
            end
            REQ1, REQ2: begin
               // An unacknowledged read cannot be withdrawn, so a flush must wait it out in DRAIN.
               if (flush_i) begin
                  state_q <= imem.ack ? ISSUE : DRAIN;
                  rd_q    <= !imem.ack;
               end else if (imem.ack) begin
                  word1_q      <= imem.rdata;
                  pend_instr_q <= instr_d;
                  len_q        <= len_d;
                  if (!done) begin
                     state_q     <= REQ2;
                     imem_addr_q <= addr_q + AW'(1);
                  end else begin
                     state_q <= write ? ISSUE : PEND;
                     rd_q    <= 1'b0;
                  end
               end
            end
            PEND: if (flush_i || !stall_i) state_q <= ISSUE;
            DRAIN: begin
               if (imem.ack) begin
                  state_q <= ISSUE;
                  rd_q    <= 1'b0;
               end
            end
            default: state_q <= ISSUE;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: directed and random checks of instr_fetch_stage against a PC/memory reference model.
module tb_instr_fetch_stage;
   localparam int AW = 32, IW = 16;
   logic          clk = 1'b0, rst, flush_i, stall_i, pc_enable_o, ifid_valid_o;
   logic [31:0]   pc_i, next_pc_o, ifid_instr_o, ifid_pc_o, ifid_next_pc_o, tgt;
   logic [15:0]   mem [256];
   int            tests = 0, fails = 0, stepn = 0, n_adv = 0, last_adv_step = 0;
   int            lat_min = 0, lat_max = 0, wait_left = 0;
   logic [31:0]   last_pc, req_addr, a0;
   bit            in_req = 0, found;
   int            n0;

   always #5 clk = ~clk;

   instr_fetch_stage_if #(.AW(AW), .IW(IW)) bus ();

   instr_fetch_stage dut (
      .clk(clk), .rst(rst), .pc_i(pc_i), .next_pc_o(next_pc_o), .pc_enable_o(pc_enable_o),
      .flush_i(flush_i), .stall_i(stall_i), .imem(bus), .ifid_valid_o(ifid_valid_o),
      .ifid_instr_o(ifid_instr_o), .ifid_pc_o(ifid_pc_o), .ifid_next_pc_o(ifid_next_pc_o)
   );

   function automatic logic [15:0] rdm(logic [31:0] a);
      return mem[a[7:0]];
   endfunction
   function automatic logic [31:0] ilen(logic [31:0] a);
      return rdm(a)[15] ? 32'd2 : 32'd1;
   endfunction
   function automatic logic [31:0] nxt(logic [31:0] a);
      return a + ilen(a);
   endfunction
   function automatic logic [31:0] iword(logic [31:0] a);
      logic [31:0] b;
      b = a + 32'd1;
      return rdm(a)[15] ? {rdm(a), rdm(b)} : {rdm(a), 16'h0000};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Memory: random latency per request, data from mem[], address must hold until ack.
   always @(negedge clk) begin
      if (rst || !bus.rd) begin
         bus.ack = 1'b0;
         in_req  = 1'b0;
      end else begin
         if (!in_req) begin
            in_req    = 1'b1;
            req_addr  = bus.addr;
            wait_left = int'($urandom_range(lat_max, lat_min));
         end else chk("addr_stable", bus.addr, req_addr);
         if (wait_left == 0) begin
            bus.ack   = 1'b1;
            bus.rdata = rdm(bus.addr);
            in_req    = 1'b0;
         end else begin
            bus.ack = 1'b0;
            wait_left--;
         end
      end
   end

   task automatic step();
      logic pe, fl, st, v;
      logic [31:0] np, i0, p0, q0, pcm;
      @(negedge clk);
      #1;
      pe = pc_enable_o; fl = flush_i; st = stall_i; v = ifid_valid_o;
      np = next_pc_o; i0 = ifid_instr_o; p0 = ifid_pc_o; q0 = ifid_next_pc_o; pcm = pc_i;
      @(posedge clk);
      #1;
      stepn++;
      if (fl) begin
         chk("flush_pcen", pe, 1);
         chk("flush_clr", ifid_valid_o, 0);
      end else if (pe) begin
         chk("no_adv_stalled", v && st, 0);
         chk("next_pc", np, nxt(pcm));
         chk("ifid_valid", ifid_valid_o, 1);
         chk("ifid_pc", ifid_pc_o, pcm);
         chk("ifid_instr", ifid_instr_o, iword(pcm));
         chk("ifid_npc", ifid_next_pc_o, nxt(pcm));
         n_adv++;
         last_adv_step = stepn;
         last_pc = pcm;
      end else if (v && st) begin
         chk("hold_valid", ifid_valid_o, 1);
         chk("hold_instr", ifid_instr_o, i0);
         chk("hold_pc", ifid_pc_o, p0);
         chk("hold_npc", ifid_next_pc_o, q0);
      end else chk("ifid_drop", ifid_valid_o, 0);
      if (pe) pc_i = fl ? tgt : nxt(pcm);
      flush_i = 1'b0;
   endtask

   task automatic wait_adv(input string tag, input logic [31:0] exp_pc);
      n0 = n_adv;
      for (int i = 0; i < 40 && n_adv == n0; i++) step();
      chk({tag, "_seen"}, n_adv != n0, 1);
      chk({tag, "_pc"}, last_pc, exp_pc);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      mem[8'h20] = 16'h1234; mem[8'h21] = 16'h8001; mem[8'h22] = 16'hBEEF;
      mem[8'hFF] = 16'h8AAA; mem[8'h00] = 16'h1111;
      rst = 1'b0; flush_i = 1'b0; stall_i = 1'b0; pc_i = 32'h20; tgt = '0;
      #1 rst = 1'b1;
      #1;
      chk("rst_rd", bus.rd, 0);
      chk("rst_addr", bus.addr, 0);
      chk("rst_valid", ifid_valid_o, 0);
      chk("rst_instr", ifid_instr_o, 0);
      chk("rst_pc", ifid_pc_o, 0);
      chk("rst_npc", ifid_next_pc_o, 0);
      chk("rst_pcen", pc_enable_o, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      step();
      chk("req1_rd", bus.rd, 1);
      chk("req1_addr", bus.addr, 32'h20);
      step();
      chk("short_lat", last_adv_step, 2);
      chk("short_instr", ifid_instr_o, 32'h12340000);
      chk("short_npc", ifid_next_pc_o, 32'h21);
      repeat (3) step();
      chk("long_lat", last_adv_step, 5);
      chk("long_instr", ifid_instr_o, 32'h8001BEEF);
      chk("long_npc", ifid_next_pc_o, 32'h23);
      stall_i = 1'b1;
      n0 = n_adv;
      repeat (6) step();
      chk("stall_no_adv", n_adv, n0);
      stall_i = 1'b0;
      step();
      chk("unstall_adv", last_adv_step, stepn);
      // Flush on the first cycle of a slow read: request must drain before refetch at 0x100.
      lat_min = 2; lat_max = 2;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (bus.rd && !in_req && !bus.ack) found = 1;
      end
      chk("find_req1", found, 1);
      a0 = bus.addr; flush_i = 1'b1; tgt = 32'h100;
      step();
      chk("drain_rd", bus.rd, 1);
      chk("drain_addr", bus.addr, a0);
      wait_adv("after_drain", 32'h100);
      // Flush coinciding with the second-word ack.
      lat_min = 0; lat_max = 0;
      mem[8'h00] = 16'h1111;
      mem[8'h01] = 16'h0123; mem[8'h02] = 16'h8123; mem[8'h03] = 16'h4567; mem[8'h04] = 16'h8000;
      flush_i = 1'b1; tgt = 32'h202;
      step();
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (bus.rd && bus.addr == 32'h203) found = 1;
      end
      chk("find_req2", found, 1);
      flush_i = 1'b1; tgt = 32'h301;
      step();
      chk("req2_flush_valid", ifid_valid_o, 0);
      wait_adv("after_req2_flush", 32'h301);
      flush_i = 1'b1; tgt = 32'hFFFF_FFFF;
      step();
      wait_adv("wrap", 32'hFFFF_FFFF);
      chk("wrap_instr", ifid_instr_o, 32'h8AAA1111);
      chk("wrap_npc", ifid_next_pc_o, 32'h1);
      // Asynchronous reset while the second word of a long instruction is outstanding.
      stall_i = 1'b1; flush_i = 1'b1; tgt = 32'h202;
      step();
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (ifid_valid_o && bus.rd && bus.addr == 32'h205) found = 1;
      end
      mem[8'h05] = 16'h2222;
      if (!found) begin
         for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (ifid_valid_o && bus.rd && bus.addr == 32'h205) found = 1;
         end
      end
      chk("find_req2_rst", found, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rd", bus.rd, 0);
      chk("async_valid", ifid_valid_o, 0);
      @(posedge clk);
      #1 rst = 1'b0; stall_i = 1'b0; pc_i = 32'h40;
      wait_adv("after_rst", 32'h40);
      lat_min = 0; lat_max = 3;
      n0 = n_adv;
      for (int i = 0; i < 3000; i++) begin
         stall_i = ($urandom_range(0, 9) < 3);
         if ($urandom_range(0, 19) == 0) begin
            flush_i = 1'b1;
            tgt = ($urandom_range(0, 7) == 0) ? 32'($urandom) : {24'h0, 8'($urandom)};
         end
         step();
      end
      chk("random_progress", n_adv > n0 + 200, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
